ps2_key_tracker: RTL
====================

# ps2_key_tracker

Receives the raw PS/2 keyboard serial stream, assembles 11-bit frames, and tracks make/break codes. Presents the current key's Set-2 scan code, its ASCII equivalent, a pressed flag and an 8-bit keystroke counter. Sits directly upstream of the seven-segment display stage, which consumes the code, ASCII and count it produces. Runs on the system clock; the PS/2 lines are treated as asynchronous inputs.

## Interface
- TIMEOUT, 50000: idle `clk` cycles inside a partial frame before the frame is abandoned (1 ms at 50 MHz).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous.
- ps2_data  in  1  raw PS/2 data from the keyboard, asynchronous.
- key_code  out  8  scan code of the most recently pressed key.
- key_ascii  out  8  ASCII for key_code; 0x00 if the code is not mapped.
- key_down  out  1  1 while key_code is held.
- key_count  out  8  number of distinct key presses, modulo 256.
- key_event  out  1  one-cycle strobe on any change of key_down or key_code.
- frame_err  out  1  one-cycle strobe on a bad or timed-out frame.

## Operation
- Synchronise ps2_clk through 3 flops and ps2_data through 2 flops. A falling edge is the cycle where sync ps2_clk[2:1] == 2'b10; sample synced ps2_data in that cycle.
- Frame receiver: bit counter 0..10, LSB-first shift register.
  - Bit 0 is the start bit and must be 0.
  - Bits 1–8 are data.
  - Bit 9 is parity: odd parity over data and parity bit.
  - Bit 10 is the stop bit and must be 1.
- After bit 10, the counter returns to 0. A valid frame produces an internal code_valid pulse with the 8-bit code. Any start, parity or stop violation pulses frame_err instead, and the code is discarded.
- Timeout: a counter runs while the bit counter is nonzero and clears on each falling edge. When it reaches TIMEOUT, the bit counter resets to 0 and frame_err pulses. A start bit of 1 also pulses frame_err and the counter stays at 0.
- Decoder FSM, states IDLE and BREAK, acting on each code_valid:
  - IDLE, code 0xF0: go to BREAK; no output change.
  - IDLE, code 0xE0: ignored; stay in IDLE. Extended keys are reported by their second byte.
  - IDLE, other code while key_down == 1 and code == key_code: typematic repeat. No change and no key_event.
  - IDLE, any other code: key_code <= code, key_ascii <= map(code), key_down <= 1, key_count <= key_count + 1 (255 wraps to 0), key_event pulses. Stay in IDLE.
  - BREAK, code == key_code: key_down <= 0, key_event pulses; key_code and key_ascii hold. Go to IDLE.
  - BREAK, any other code: no output change; go to IDLE.
- ASCII map (lower-case letters and digits only; every other code gives 0x00):
  - a1C b32 c21 d23 e24 f2B g34 h33 i43 j3B k42 l4B m3A
  - n31 o44 p4D q15 r2D s1B t2C u3C v2A w1D x22 y35 z1A
  - 0-45 1-16 2-1E 3-26 4-25 5-2E 6-36 7-3D 8-3E 9-46
- Reset values: key_code 0x00, key_ascii 0x00, key_down 0, key_count 0x00, key_event 0, frame_err 0. FSM goes to IDLE; bit and timeout counters go to 0; sync flops go to 1 (bus idle high).

## Timing
- Synchroniser latency is 2–3 clk cycles from a ps2_clk fall to edge detection.
- code_valid and frame_err are registered one cycle after the 11th detected edge. Decoder outputs and key_event update one cycle after code_valid.
- Total latency: outputs change exactly 2 clk cycles after the cycle the 11th edge is detected.
- key_event and frame_err are single-cycle pulses, never stretched.
- key_ascii always updates in the same cycle as key_code.
- rst asserted mid-frame discards the partial frame. The first frame after release must start from a fresh falling edge on the start bit.
- ps2_clk period (60–100 µs) is far longer than the clk period. At most one code_valid occurs per frame, so the decoder needs no back-pressure.

## Test plan
- Press A: send frame 0x1C. Expect key_code 0x1C, key_ascii 0x61, key_down 1, key_count 1, one key_event.
- Typematic then release: send 0x1C ×3, then 0xF0, 0x1C. Expect key_count to stay 1 with no key_event during the repeats; after the 0x1C following F0, key_down 0, key_code still 0x1C, one key_event.
- Parity error: send 0x24 with even parity. Expect one frame_err pulse and all outputs unchanged. A following good 0x24 gives key_ascii 0x65 and key_count incremented by 1.
- Timeout: send 5 edges, then idle for TIMEOUT+1 cycles. Expect one frame_err pulse. A following good 0x45 gives key_code 0x45 and key_ascii 0x30.
- Wrap and unmapped codes: alternate press 0x16 / 0x1E 256 times. Expect key_count 0x00 afterwards. Then press 0x05 (F1): key_ascii 0x00, key_count 0x01.
- Reset mid-frame: assert rst after 6 bits of a frame. Expect all outputs at reset values immediately. A clean frame 0x1A after release gives key_ascii 0x7A and key_count 1.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker -- PS/2 frame receiver with make/break key tracking and ASCII lookup.
// Revision 1.0
`default_nettype none

module ps2_key_tracker #(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic [7:0] key_ascii,
  output logic       key_down,
  output logic [7:0] key_count,
  output logic       key_event,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BREAK = 1'b1} state_t;

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          fall;
  logic          bit_in;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity;
  logic [TW-1:0] idle_cnt;
  logic          code_valid;
  logic [7:0]    code;

  state_t        state, state_n;
  logic [7:0]    code_n, ascii_n, count_n;
  logic          down_n, event_n;

  function automatic logic [7:0] ascii_of(input logic [7:0] c);
    case (c)
      8'h1C: ascii_of = 8'h61; 8'h32: ascii_of = 8'h62; 8'h21: ascii_of = 8'h63;
      8'h23: ascii_of = 8'h64; 8'h24: ascii_of = 8'h65; 8'h2B: ascii_of = 8'h66;
      8'h34: ascii_of = 8'h67; 8'h33: ascii_of = 8'h68; 8'h43: ascii_of = 8'h69;
      8'h3B: ascii_of = 8'h6A; 8'h42: ascii_of = 8'h6B; 8'h4B: ascii_of = 8'h6C;
      8'h3A: ascii_of = 8'h6D; 8'h31: ascii_of = 8'h6E; 8'h44: ascii_of = 8'h6F;
      8'h4D: ascii_of = 8'h70; 8'h15: ascii_of = 8'h71; 8'h2D: ascii_of = 8'h72;
      8'h1B: ascii_of = 8'h73; 8'h2C: ascii_of = 8'h74; 8'h3C: ascii_of = 8'h75;
      8'h2A: ascii_of = 8'h76; 8'h1D: ascii_of = 8'h77; 8'h22: ascii_of = 8'h78;
      8'h35: ascii_of = 8'h79; 8'h1A: ascii_of = 8'h7A;
      8'h45: ascii_of = 8'h30; 8'h16: ascii_of = 8'h31; 8'h1E: ascii_of = 8'h32;
      8'h26: ascii_of = 8'h33; 8'h25: ascii_of = 8'h34; 8'h2E: ascii_of = 8'h35;
      8'h36: ascii_of = 8'h36; 8'h3D: ascii_of = 8'h37; 8'h3E: ascii_of = 8'h38;
      8'h46: ascii_of = 8'h39;
      default: ascii_of = 8'h00;
    endcase
  endfunction

  // Sync flops reset high so a released bus never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall   = (clk_sync[2:1] == 2'b10);
  assign bit_in = data_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      parity     <= 1'b0;
      idle_cnt   <= '0;
      code_valid <= 1'b0;
      code       <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (bit_in) frame_err <= 1'b1;
          else        bit_cnt   <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shift   <= {bit_in, shift[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          parity  <= bit_in;
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if (bit_in && (^{shift, parity})) begin
            code_valid <= 1'b1;
            code       <= shift;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT - 1)) begin
          bit_cnt   <= 4'd0;
          idle_cnt  <= '0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    code_n  = key_code;
    ascii_n = key_ascii;
    down_n  = key_down;
    count_n = key_count;
    event_n = 1'b0;
    if (code_valid) begin
      case (state)
        S_IDLE: begin
          if (code == 8'hF0) begin
            state_n = S_BREAK;
          end else if (code == 8'hE0) begin
            state_n = S_IDLE;
          end else if (!(key_down && code == key_code)) begin
            code_n  = code;
            ascii_n = ascii_of(code);
            down_n  = 1'b1;
            count_n = key_count + 8'd1;
            event_n = 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          if (code == key_code) begin
            down_n  = 1'b0;
            event_n = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      key_code  <= 8'h00;
      key_ascii <= 8'h00;
      key_down  <= 1'b0;
      key_count <= 8'h00;
      key_event <= 1'b0;
    end else begin
      state     <= state_n;
      key_code  <= code_n;
      key_ascii <= ascii_n;
      key_down  <= down_n;
      key_count <= count_n;
      key_event <= event_n;
    end
  end

endmodule

`default_nettype wire
